mux8_sel_reg: RTL and testbench

- WIDTH-lane 8-to-1 multiplexer. Each lane selects one of eight inputs with a shared 3-bit select.
- Built hierarchically from the existing primitives mux4_1 and mux2_1:
  - two 4:1 stages on sel[1:0];
  - one 2:1 stage on sel[2].
- Provides a combinational output and a registered, valid-qualified copy, for use in datapath select and readback paths.

---
 rtl/mux8_sel_reg.sv | 94 +++++++++
 tb/tb_mux8_sel_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_sel_reg.sv
// WIDTH-lane 8:1 mux built from mux4_1/mux2_1, with a registered copy.
// Optional MUX8_SEL_PARITY_EN adds a registered parity output out_par.

module mux2_1 (
    input  logic in0,
    input  logic in1,
    input  logic sel,
    output logic out
);
    assign out = sel ? in1 : in0;
endmodule

module mux4_1 (
    input  logic [3:0] in,
    input  logic [1:0] sel,
    output logic       out
);
    assign out = in[sel];
endmodule

module mux8_sel_reg #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [8*WIDTH-1:0] in,
    input  logic [2:0]         sel,
    output logic [WIDTH-1:0]   out,
    output logic [WIDTH-1:0]   out_q,
    output logic               out_valid
`ifdef MUX8_SEL_PARITY_EN
    ,
    output logic               out_par
`endif
);

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        logic [3:0] lo_in;
        logic [3:0] hi_in;
        logic       lo;
        logic       hi;

        // gather this lane's bit from each of the eight inputs
        for (genvar i = 0; i < 4; i++) begin : g_tap
            assign lo_in[i] = in[i*WIDTH + k];
            assign hi_in[i] = in[(i+4)*WIDTH + k];
        end

        mux4_1 u_lo (
            .in  (lo_in),
            .sel (sel[1:0]),
            .out (lo)
        );

        mux4_1 u_hi (
            .in  (hi_in),
            .sel (sel[1:0]),
            .out (hi)
        );

        mux2_1 u_top (
            .in0 (lo),
            .in1 (hi),
            .sel (sel[2]),
            .out (out[k])
        );
    end

    // capture the selected value when qualified; valid follows in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q <= out;
            end
        end
    end

`ifdef MUX8_SEL_PARITY_EN
    // parity of the captured value, loaded together with out_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (in_valid) begin
            out_par <= ^out;
        end
    end
`endif

endmodule

// File: tb/tb_mux8_sel_reg.sv
// Self-checking bench for mux8_sel_reg, WIDTH=1 and WIDTH=4 instances.
// Directed sweeps, reset checks and randomized traffic against a model.

module tb_mux8_sel_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v = 1'b0;
    logic [7:0]  in1 = '0;
    logic [2:0]  sel1 = '0;
    logic [31:0] in4 = '0;
    logic [2:0]  sel4 = '0;
    logic [0:0]  out1, q1;
    logic [3:0]  out4, q4;
    logic        ov1, ov4;
`ifdef MUX8_SEL_PARITY_EN
    logic        par1, par4;
`endif

    int total = 0;
    int bad = 0;

    // model state for the registered path
    logic [0:0] m_q1;
    logic [3:0] m_q4;
    logic       m_v;
    logic       m_p1, m_p4;

    always #5 clk = ~clk;

    mux8_sel_reg #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v),
        .in        (in1),
        .sel       (sel1),
        .out       (out1),
        .out_q     (q1),
        .out_valid (ov1)
`ifdef MUX8_SEL_PARITY_EN
        ,
        .out_par   (par1)
`endif
    );

    mux8_sel_reg #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v),
        .in        (in4),
        .sel       (sel4),
        .out       (out4),
        .out_q     (q4),
        .out_valid (ov4)
`ifdef MUX8_SEL_PARITY_EN
        ,
        .out_par   (par4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // input s of a WIDTH-lane bundle, viewed as eight WIDTH-bit words
    function automatic logic [3:0] pick(input logic [31:0] bus,
                                        input int s, input int w);
        logic [3:0] words [8];
        for (int i = 0; i < 8; i++)
            words[i] = 4'((bus >> (i*w)) & ((32'd1 << w) - 1));
        return words[s];
    endfunction

    function automatic logic par(input logic [3:0] x);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(x[i]);
        return logic'(n % 2);
    endfunction

    task automatic check_regs(input string tag);
        check({tag, " q1"}, 32'(q1), 32'(m_q1));
        check({tag, " q4"}, 32'(q4), 32'(m_q4));
        check({tag, " v1"}, 32'(ov1), 32'(m_v));
        check({tag, " v4"}, 32'(ov4), 32'(m_v));
`ifdef MUX8_SEL_PARITY_EN
        check({tag, " p1"}, 32'(par1), 32'(m_p1));
        check({tag, " p4"}, 32'(par4), 32'(m_p4));
`endif
    endtask

    // advance one edge and update the model the way the spec describes
    task automatic step();
        logic [3:0] e1, e4;
        e1 = pick({24'd0, in1}, int'(sel1), 1);
        e4 = pick(in4, int'(sel4), 4);
        @(posedge clk);
        m_v = v;
        if (v) begin
            m_q1 = e1[0:0];
            m_q4 = e4;
            m_p1 = e1[0];
            m_p4 = par(e4);
        end
        #1;
    endtask

    task automatic model_reset();
        m_q1 = '0;
        m_q4 = '0;
        m_v  = 1'b0;
        m_p1 = 1'b0;
        m_p4 = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [3:0] exp4;
        model_reset();
        #12;
        check_regs("reset");

        // sweep with 8'hCA then its inverse
        pat = 8'hCA;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < 8; s++) begin
                in1 = pat;
                sel1 = 3'(s);
                #10;
                check($sformatf("sweep%0d s%0d", p, s), 32'(out1),
                      32'(pat[s]));
            end
            pat = ~pat;
        end

        @(negedge clk);
        rst_n = 1'b1;

        // registered path
        @(negedge clk);
        v = 1'b1; in1 = 8'hCA; sel1 = 3'd7;
        step();
        check("cap q", 32'(q1), 32'd1);
        check("cap v", 32'(ov1), 32'd1);
        @(negedge clk);
        v = 1'b0; sel1 = 3'd0;
        step();
        check("hold q", 32'(q1), 32'd1);
        check("hold v", 32'(ov1), 32'd0);

        // async reset between edges
        @(negedge clk);
        v = 1'b1; sel1 = 3'd7;
        step();
        check_regs("pre-rst");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("async rst");
        sel1 = 3'd1;
        #1;
        check("out in rst", 32'(out1), 32'd1);
        @(negedge clk);
        v = 1'b0;
        rst_n = 1'b1;

        // WIDTH=4: lane k input i = (i+k)%2
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 4; k++)
                in4[i*4 + k] = logic'((i + k) % 2);
        for (int s = 0; s < 8; s++) begin
            sel4 = 3'(s);
            #1;
            for (int k = 0; k < 4; k++) exp4[k] = logic'((s + k) % 2);
            check($sformatf("lanes s%0d", s), 32'(out4), 32'(exp4));
        end

        // capture 4'b1011 on the wide instance
        @(negedge clk);
        in4 = 32'h0000_000B; sel4 = 3'd0; v = 1'b1;
        step();
        check("q4 1011", 32'(q4), 32'hB);
`ifdef MUX8_SEL_PARITY_EN
        check("par 1011", 32'(par4), 32'd1);
`endif

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            v    = logic'($urandom_range(0, 1));
            in1  = 8'($urandom);
            sel1 = 3'($urandom_range(0, 7));
            in4  = $urandom;
            sel4 = 3'($urandom_range(0, 7));
            #1;
            exp4 = pick({24'd0, in1}, int'(sel1), 1);
            check("rnd out1", 32'(out1), 32'(exp4[0]));
            check("rnd out4", 32'(out4), 32'(pick(in4, int'(sel4), 4)));
            step();
            check_regs("rnd");
            if (n == 150) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_regs("rnd rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule
